// File: rtl/csa_resolve_pipe_if.sv
// csa_resolve_pipe_if
//   Handshake bundle for the carry-save resolve pipeline.
//   Input side : in_valid/in_ready with the redundant pair in_sum/in_carry.
//   Output side: out_valid/out_ready with the resolved word out_result and
//                the carry out of the top bit, out_cout.
//   Optional   : out_zero when CSA_RESOLVE_ZERO_FLAG_EN is defined.
//   Modports   : slave  - the pipeline (consumes pairs, produces results)
//                master - the environment (produces pairs, consumes results)
interface csa_resolve_pipe_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic [WIDTH-1:0] in_carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_cout;
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
    logic             out_zero;
`endif

    modport slave (
        input  in_valid,
        input  in_sum,
        input  in_carry,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_result,
        output out_cout
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
        ,
        output out_zero
`endif
    );

    modport master (
        output in_valid,
        output in_sum,
        output in_carry,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_result,
        input  out_cout
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
        ,
        input  out_zero
`endif
    );
endinterface

// File: rtl/csa_resolve_pipe.sv
// csa_resolve_pipe
//   Final carry-propagate adder for the Wallace-tree multiplier. Resolves the
//   (sum, carry) pair from the compressor tree into one binary word, CHUNK bits
//   per pipeline stage so no full-width ripple path exists.
//
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - csa_resolve_pipe_if.slave: in_valid/in_ready/in_sum/in_carry,
//              out_valid/out_ready/out_result/out_cout (+ out_zero)
//
//   Parameters: WIDTH (result width), CHUNK (bits per stage, must divide
//   WIDTH). STAGES = WIDTH/CHUNK is derived.
//
//   Optional feature macro: CSA_RESOLVE_ZERO_FLAG_EN adds out_zero, high with
//   out_valid when out_result is all zeros (out_cout ignored).
//
//   Stage k register contents: res_q[k] holds slices 0..k resolved and the
//   upper slices still as raw sum bits; car_q[k] carries the raw carry vector
//   forward for the slices not yet resolved; cy_q[k] is the slice k carry-out.
module csa_resolve_pipe #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    csa_resolve_pipe_if.slave      bus
);
    localparam int STAGES = WIDTH / CHUNK;
    // Last stage never forwards a carry vector; keep the array non-empty.
    localparam int NCAR   = (STAGES > 1) ? STAGES - 1 : 1;

    if (CHUNK <= 0 || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("csa_resolve_pipe: WIDTH must be a positive multiple of CHUNK");
    end

    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] cy_q, cy_d;
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  res_d [STAGES];
    logic [WIDTH-1:0]  car_q [NCAR];
    logic [WIDTH-1:0]  car_d [NCAR];
    logic [STAGES-1:0] ld;

    // Per-stage view of what is upstream (input port for stage 0).
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_cin;
    logic [WIDTH-1:0]  src_res [STAGES];
    logic [WIDTH-1:0]  src_car [STAGES];

`ifdef CSA_RESOLVE_ZERO_FLAG_EN
    logic [STAGES-1:0] zero_q, zero_d;
    logic [STAGES-1:0] src_zin;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_src
        if (k == 0) begin : g_first
            assign src_v[0]   = bus.in_valid;
            assign src_res[0] = bus.in_sum;
            assign src_car[0] = bus.in_carry;
            assign src_cin[0] = 1'b0;
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
            assign src_zin[0] = 1'b1;
`endif
        end else begin : g_next
            assign src_v[k]   = v_q[k-1];
            assign src_res[k] = res_q[k-1];
            assign src_car[k] = car_q[k-1];
            assign src_cin[k] = cy_q[k-1];
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
            assign src_zin[k] = zero_q[k-1];
`endif
        end
    end

    always_comb begin
        logic             down_ok;
        logic [CHUNK:0]   slice;

        // Load enables ripple from the output back to the input: a stage may
        // take new contents if it is empty or its occupant moves on this edge.
        down_ok = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ld[k]   = !v_q[k] || down_ok;
            down_ok = ld[k];
        end

        slice = '0;
        for (int k = 0; k < NCAR; k++) begin
            car_d[k] = car_q[k];
        end

        for (int k = 0; k < STAGES; k++) begin
            slice = {1'b0, src_res[k][k*CHUNK +: CHUNK]}
                  + {1'b0, src_car[k][k*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, src_cin[k]};

            v_d[k]   = ld[k] ? src_v[k] : v_q[k];
            res_d[k] = res_q[k];
            cy_d[k]  = cy_q[k];
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
            zero_d[k] = zero_q[k];
`endif
            // Data only moves with a valid occupant so bubbles leave the
            // registers (and out_result) untouched.
            if (ld[k] && src_v[k]) begin
                res_d[k]                   = src_res[k];
                res_d[k][k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
                cy_d[k]                    = slice[CHUNK];
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
                zero_d[k] = src_zin[k] && (slice[CHUNK-1:0] == '0);
`endif
            end
        end

        for (int k = 0; k < STAGES - 1; k++) begin
            if (ld[k] && src_v[k]) begin
                car_d[k] = src_car[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q  <= '0;
            cy_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k] <= '0;
            end
            for (int k = 0; k < NCAR; k++) begin
                car_q[k] <= '0;
            end
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
            zero_q <= '0;
`endif
        end else begin
            v_q  <= v_d;
            cy_q <= cy_d;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k] <= res_d[k];
            end
            for (int k = 0; k < NCAR; k++) begin
                car_q[k] <= car_d[k];
            end
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
            zero_q <= zero_d;
`endif
        end
    end

    assign bus.in_ready   = ld[0];
    assign bus.out_valid  = v_q[STAGES-1];
    assign bus.out_result = res_q[STAGES-1];
    assign bus.out_cout   = cy_q[STAGES-1];
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
    assign bus.out_zero   = zero_q[STAGES-1];
`endif

endmodule

// File: tb/tb_csa_resolve_pipe.sv
// tb_csa_resolve_pipe
//   Directed bench for csa_resolve_pipe (WIDTH=64, CHUNK=16, 4 stages).
//   Expected results come from a plain 65-bit add of sum and carry.
module tb_csa_resolve_pipe;
    localparam int WIDTH  = 64;
    localparam int CHUNK  = 16;
    localparam int STAGES = WIDTH / CHUNK;

    logic clk;
    logic rst_n;

    csa_resolve_pipe_if #(.WIDTH(WIDTH)) bus ();

    csa_resolve_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total;
    int          bad;
    int          n_out;
    bit          stall_prev;
    logic [64:0] held;
    logic [64:0] exp_q [$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // One clock: observe handshakes at the falling edge, then step past the
    // next rising edge. Inputs are changed by the caller afterwards.
    task automatic cyc(output bit acc);
        logic [64:0] got;
        logic [64:0] exp_v;
        @(negedge clk);
        got = {bus.out_cout, bus.out_result};
        if (stall_prev) begin
            check("hold_valid", 65'(bus.out_valid), 65'(1));
            check("hold_data", got, held);
        end
        if (bus.out_valid && bus.out_ready) begin
            n_out++;
            check("sb_pending", 65'(exp_q.size() != 0), 65'(1));
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                check("sb_result", got, exp_v);
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
                check("sb_zero", 65'(bus.out_zero), 65'(exp_v[63:0] == 64'd0));
`endif
            end
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        held       = got;
        acc        = bus.in_valid && bus.in_ready;
        if (acc) exp_q.push_back({1'b0, bus.in_sum} + {1'b0, bus.in_carry});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit a;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc(a);
        check("drain_empty", 65'(exp_q.size()), 65'(0));
        check("drain_idle", 65'(bus.out_valid), 65'(0));
    endtask

    // Single pair with hand-computed result; measures latency in edges after
    // the accepting edge.
    task automatic single(input logic [63:0] s, input logic [63:0] c,
                          input logic [63:0] er, input bit ec, input bit ez,
                          input string tag);
        int cnt;
        stall_prev    = 1'b0;
        bus.in_sum    = s;
        bus.in_carry  = c;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_in_ready"}, 65'(bus.in_ready), 65'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        cnt = 0;
        @(negedge clk);
        while (!bus.out_valid && cnt < 20) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 65'(cnt), 65'(STAGES - 1));
        check({tag, "_result"}, {1'b0, bus.out_result}, {1'b0, er});
        check({tag, "_cout"}, 65'(bus.out_cout), 65'(ec));
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
        check({tag, "_zero"}, 65'(bus.out_zero), 65'(ez));
`else
        if (ez && !ez) $display("unreachable");
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit a;
        int n;
        int k;
        int stalls;
        int n0;

        total = 0;
        bad = 0;
        n_out = 0;
        stall_prev = 1'b0;
        held = '0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sum = '0;
        bus.in_carry = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 65'(bus.out_valid), 65'(0));
        check("rst_out_result", {1'b0, bus.out_result}, 65'(0));
        check("rst_out_cout", 65'(bus.out_cout), 65'(0));
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
        check("rst_out_zero", 65'(bus.out_zero), 65'(0));
`endif
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 65'(bus.in_ready), 65'(1));
        @(posedge clk);
        #1;

        single(64'h5, 64'hA, 64'hF, 1'b0, 1'b0, "t_small");
        single(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 1'b1, "t_ripple");
        single(64'h0000_0000_0000_FFFF, 64'h1, 64'h0000_0000_0001_0000, 1'b0, 1'b0, "t_slice0");
        single(64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 64'h0, 1'b1, 1'b1, "t_upper");
        single(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111,
               64'h2345_6789_ABCD_F001, 1'b0, 1'b0, "t_nocarry");

        // Back-to-back stream, sink always ready.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_sum    = rnd64();
        bus.in_carry  = rnd64();
        n = 0;
        stalls = 0;
        n0 = n_out;
        for (int i = 0; i < 200 && n < 100; i++) begin
            cyc(a);
            if (a) begin
                n++;
                bus.in_sum   = rnd64();
                bus.in_carry = rnd64();
            end else begin
                stalls++;
            end
        end
        bus.in_valid = 1'b0;
        check("stream_accepted", 65'(n), 65'(100));
        check("stream_stalls", 65'(stalls), 65'(0));
        drain();
        check("stream_outputs", 65'(n_out - n0), 65'(100));

        // Backpressure: sink blocked, offer six pairs.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        k = 0;
        n0 = n_out;
        bus.in_sum   = (64'(k + 1) << 48) | 64'hFFFF;
        bus.in_carry = 64'h1;
        for (int i = 0; i < 8; i++) begin
            cyc(a);
            if (a) begin
                k++;
                bus.in_sum   = (64'(k + 1) << 48) | 64'hFFFF;
                bus.in_carry = 64'h1;
            end
        end
        check("bp_accepted", 65'(k), 65'(STAGES));
        check("bp_in_ready", 65'(bus.in_ready), 65'(0));
        check("bp_out_valid", 65'(bus.out_valid), 65'(1));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 30 && k < 6; i++) begin
            cyc(a);
            if (a) begin
                k++;
                bus.in_sum   = (64'(k + 1) << 48) | 64'hFFFF;
                bus.in_carry = 64'h1;
            end
        end
        bus.in_valid = 1'b0;
        check("bp_total_accepted", 65'(k), 65'(6));
        drain();
        check("bp_outputs", 65'(n_out - n0), 65'(6));

        // Random valid/ready toggling; source holds a pair until it is taken.
        a = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            if (!bus.in_valid || a) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_sum   = rnd64();
                bus.in_carry = rnd64();
            end
            cyc(a);
        end
        drain();

        // Asynchronous reset with three pairs in flight.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        n = 0;
        for (int i = 0; i < 10 && n < 3; i++) begin
            bus.in_sum   = rnd64();
            bus.in_carry = rnd64();
            cyc(a);
            if (a) n++;
        end
        bus.in_valid = 1'b0;
        check("rst_mid_accepted", 65'(n), 65'(3));
        cyc(a);
        check("rst_mid_pre_valid", 65'(bus.out_valid), 65'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 65'(bus.out_valid), 65'(0));
        check("rst_mid_result", {1'b0, bus.out_result}, 65'(0));
        check("rst_mid_cout", 65'(bus.out_cout), 65'(0));
        exp_q.delete();
        stall_prev = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        n0 = n_out;
        repeat (6) cyc(a);
        check("rst_no_ghost", 65'(n_out - n0), 65'(0));
        single(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1'b1, 1'b1, "t_post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
